// File: rtl/dp_pkg.sv
// Shared types and constants for the data-plane packet link.
package dp_pkg;
  localparam logic [15:0] IDLE_ID      = 16'hFFFF;
  localparam int          DP_BURST_LEN = 5;

  typedef struct packed {
    logic [15:0] dest;
    logic [15:0] data;
  } dp_packet_t;

  typedef enum logic [1:0] {IDLE, SEND, DONE} dp_tx_state_t;

  function automatic dp_packet_t idle_pkt();
    return '{dest: IDLE_ID, data: 16'h0000};
  endfunction
endpackage

// File: rtl/dp_tx_fifo.sv
// Show-ahead FIFO for GPP words; read data is combinational from the head entry.
// Push on full is dropped unless a pop frees the slot in the same cycle.
module dp_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/data_plane_tx.sv
// Data-plane transmitter: drains BURST_LEN FIFO words as {dest,data} packets per accepted tx_start.
// DP_TX_PAD_EN: accept short bursts (count >= 1) and pad missing beats with zero data.
module data_plane_tx
  import dp_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int BURST_LEN = DP_BURST_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] node_id,
  input  logic        gpp_wtr_dp,
  input  logic [15:0] gpp_tx_data,
  input  logic        tx_start,
  input  logic [15:0] tx_dest_id,
  output logic [31:0] data_tx_packet,
  output logic        data_tx_busy,
  output logic        data_tx_complete_flag,
  output logic        tx_reject,
  output logic        tx_full,
  output logic        tx_empty
);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  dp_tx_state_t      state_q, state_d;
  logic [15:0]       dest_q, dest_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  dp_packet_t        pkt_q, pkt_d;
  logic              busy_q, busy_d;
  logic              complete_q, complete_d;
  logic              reject_q, reject_d;

  logic              fifo_pop;
  logic [15:0]       fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;
  logic              id_ok, cnt_ok;

  dp_tx_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (gpp_wtr_dp),
    .wdata_i (gpp_tx_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (fifo_count)
  );

  assign id_ok = (tx_dest_id != node_id) && (tx_dest_id != IDLE_ID);
`ifdef DP_TX_PAD_EN
  assign cnt_ok = (fifo_count != '0);
`else
  assign cnt_ok = (fifo_count >= CNT_W'(BURST_LEN));
`endif

  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    beat_d     = beat_q;
    pkt_d      = pkt_q;
    busy_d     = busy_q;
    complete_d = 1'b0;
    reject_d   = 1'b0;
    fifo_pop   = 1'b0;
    case (state_q)
      IDLE: begin
        pkt_d = idle_pkt();
        if (tx_start) begin
          if (id_ok && cnt_ok) begin
            dest_d  = tx_dest_id;
            beat_d  = '0;
            busy_d  = 1'b1;
            state_d = SEND;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      SEND: begin
        // An empty FIFO here only occurs on padded bursts; emit zero data without popping.
        fifo_pop = !tx_empty;
        pkt_d    = '{dest: dest_q, data: tx_empty ? 16'h0000 : fifo_rdata};
        beat_d   = beat_q + BEAT_W'(1);
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        pkt_d      = idle_pkt();
        complete_d = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dest_q     <= IDLE_ID;
      beat_q     <= '0;
      pkt_q      <= idle_pkt();
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      dest_q     <= dest_d;
      beat_q     <= beat_d;
      pkt_q      <= pkt_d;
      busy_q     <= busy_d;
      complete_q <= complete_d;
      reject_q   <= reject_d;
    end
  end

  assign data_tx_packet        = pkt_q;
  assign data_tx_busy          = busy_q;
  assign data_tx_complete_flag = complete_q;
  assign tx_reject             = reject_q;
endmodule

// File: tb/tb_data_plane_tx.sv
// Directed bench for data_plane_tx: FIFO model plus packet scoreboard, checked with immediate assertions.
module tb_data_plane_tx;
  import dp_pkg::*;

  localparam int DEPTH = 16;
  localparam int BL    = 5;
  localparam logic [31:0] IDLE_W = {16'hFFFF, 16'h0000};

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] node_id;
  logic        gpp_wtr_dp;
  logic [15:0] gpp_tx_data;
  logic        tx_start;
  logic [15:0] tx_dest_id;
  logic [31:0] data_tx_packet;
  logic        data_tx_busy;
  logic        data_tx_complete_flag;
  logic        tx_reject;
  logic        tx_full;
  logic        tx_empty;

  int checks = 0;
  int errors = 0;
  logic [15:0] model[$];
  logic [31:0] sb[$];

  data_plane_tx #(.DEPTH(DEPTH), .BURST_LEN(BL)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .node_id               (node_id),
    .gpp_wtr_dp            (gpp_wtr_dp),
    .gpp_tx_data           (gpp_tx_data),
    .tx_start              (tx_start),
    .tx_dest_id            (tx_dest_id),
    .data_tx_packet        (data_tx_packet),
    .data_tx_busy          (data_tx_busy),
    .data_tx_complete_flag (data_tx_complete_flag),
    .tx_reject             (tx_reject),
    .tx_full               (tx_full),
    .tx_empty              (tx_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] w);
    gpp_wtr_dp  = 1'b1;
    gpp_tx_data = w;
    if (model.size() < DEPTH) model.push_back(w);
    @(negedge clk);
    gpp_wtr_dp = 1'b0;
  endtask

  function automatic bit can_accept(input logic [15:0] dest);
    if (dest == node_id || dest == 16'hFFFF) return 1'b0;
`ifdef DP_TX_PAD_EN
    return model.size() >= 1;
`else
    return model.size() >= BL;
`endif
  endfunction

  task automatic run_burst(input logic [15:0] dest, input bit mid_push, input logic [15:0] mid_w);
    tx_dest_id = dest;
    tx_start   = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    chk("busy_start", data_tx_busy, 32'd1);
    chk("pkt_before_first", data_tx_packet, IDLE_W);
    for (int i = 0; i < BL; i++) begin
      if (model.size() > 0) sb.push_back({dest, model.pop_front()});
      else                  sb.push_back({dest, 16'h0000});
    end
    if (mid_push) begin
      gpp_wtr_dp  = 1'b1;
      gpp_tx_data = mid_w;
      model.push_back(mid_w);
    end
    for (int i = 0; i < BL; i++) begin
      @(negedge clk);
      gpp_wtr_dp = 1'b0;
      chk("pkt_beat", data_tx_packet, sb.pop_front());
      chk("busy_beat", data_tx_busy, 32'd1);
      chk("cmpl_beat", data_tx_complete_flag, 32'd0);
    end
    @(negedge clk);
    chk("cmpl_pulse", data_tx_complete_flag, 32'd1);
    chk("pkt_done", data_tx_packet, IDLE_W);
    chk("busy_done", data_tx_busy, 32'd0);
    @(negedge clk);
    chk("cmpl_drop", data_tx_complete_flag, 32'd0);
  endtask

  task automatic run_reject(input logic [15:0] dest);
    tx_dest_id = dest;
    tx_start   = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    chk("reject_pulse", tx_reject, 32'd1);
    chk("reject_pkt", data_tx_packet, IDLE_W);
    chk("reject_busy", data_tx_busy, 32'd0);
    @(negedge clk);
    chk("reject_drop", tx_reject, 32'd0);
    chk("reject_pkt2", data_tx_packet, IDLE_W);
  endtask

  task automatic start(input logic [15:0] dest);
    if (can_accept(dest)) run_burst(dest, 1'b0, 16'h0000);
    else                  run_reject(dest);
  endtask

  initial begin
    rst         = 1'b1;
    node_id     = 16'h0001;
    gpp_wtr_dp  = 1'b0;
    gpp_tx_data = 16'h0000;
    tx_start    = 1'b0;
    tx_dest_id  = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_pkt", data_tx_packet, IDLE_W);
    chk("rst_busy", data_tx_busy, 32'd0);
    chk("rst_cmpl", data_tx_complete_flag, 32'd0);
    chk("rst_reject", tx_reject, 32'd0);
    chk("rst_empty", tx_empty, 32'd1);
    chk("rst_full", tx_full, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic burst of exactly BURST_LEN words.
    for (int i = 0; i < BL; i++) push_word(16'h00A0 + 16'(i));
    chk("empty_loaded", tx_empty, 32'd0);
    run_burst(16'h0003, 1'b0, 16'h0000);
    chk("empty_after_burst", tx_empty, 32'd1);

    // Illegal destinations are refused without touching the queue.
    for (int i = 0; i < 8; i++) push_word(16'h00B0 + 16'(i));
    run_reject(16'h0001);
    run_reject(16'hFFFF);
    chk("empty_after_rejects", tx_empty, 32'd0);
    run_burst(16'h0002, 1'b0, 16'h0000);

    // Three words left: rejected, or padded when short bursts are enabled.
    start(16'h0005);

    // Fill to DEPTH, overflow push must be dropped.
    for (int i = 0; model.size() < DEPTH; i++) push_word(16'h00F0 + 16'(i));
    chk("full_at_depth", tx_full, 32'd1);
    push_word(16'hDEAD);
    chk("full_after_drop", tx_full, 32'd1);

    // Burst from a full FIFO with a concurrent push, then drain another burst.
    run_burst(16'h0007, 1'b1, 16'h00E1);
    chk("not_full_after", tx_full, 32'd0);
    start(16'h0009);
    chk("empty_mid", tx_empty, 32'd0);

    // Reset in the middle of a burst.
    tx_dest_id = 16'h0004;
    tx_start   = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    for (int i = 0; i < BL; i++) sb.push_back({16'h0004, model.pop_front()});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("pkt_pre_rst", data_tx_packet, sb.pop_front());
    end
    rst = 1'b1;
    #1;
    model.delete();
    sb.delete();
    chk("rst_mid_pkt", data_tx_packet, IDLE_W);
    chk("rst_mid_busy", data_tx_busy, 32'd0);
    chk("rst_mid_empty", tx_empty, 32'd1);
    @(negedge clk);
    chk("rst_mid_cmpl", data_tx_complete_flag, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmpl", data_tx_complete_flag, 32'd0);

    // Empty FIFO always refuses.
    run_reject(16'h0003);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
